// File: rtl/fm_spy_buffer_ch_if.sv
// Bus bundle for one spy-buffer channel: capture stream, control,
// playback stream, AXI word readout and metadata.
interface fm_spy_buffer_ch_if #(
  parameter int DATA_W = 128,
  parameter int AXI_DW = 32,
  parameter int DEPTH  = 1024
);
  localparam int AW  = $clog2(DEPTH);
  localparam int NW  = (DATA_W + AXI_DW - 1) / AXI_DW;
  localparam int WPR = (DATA_W <= AXI_DW) ? 1 : (NW + (NW % 2));
  localparam int RW  = $clog2(DEPTH * WPR);

  logic [1:0]        pb_mode;
  logic              freeze_req;
  logic              rearm;
  logic [AW-1:0]     post_trig;
  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic [DATA_W-1:0] pb_data;
  logic              pb_vld;
  logic              rd_en;
  logic [RW-1:0]     rd_addr;
  logic [AXI_DW-1:0] rd_data;
  logic              rd_vld;
  logic [AW-1:0]     meta_wr_ptr;
  logic              meta_wrapped;
  logic              meta_frozen;

  modport slave (
    input  pb_mode, freeze_req, rearm, post_trig, in_data, in_vld, rd_en, rd_addr,
    output pb_data, pb_vld, rd_data, rd_vld, meta_wr_ptr, meta_wrapped, meta_frozen
  );
  modport master (
    output pb_mode, freeze_req, rearm, post_trig, in_data, in_vld, rd_en, rd_addr,
    input  pb_data, pb_vld, rd_data, rd_vld, meta_wr_ptr, meta_wrapped, meta_frozen
  );
endinterface

// File: rtl/fm_spy_buffer_ch.sv
// Single-channel fast-monitoring spy buffer: circular capture with
// post-trigger freeze, AXI word readout and once/loop playback.
module fm_spy_buffer_ch #(
  parameter int DATA_W = 128,
  parameter int AXI_DW = 32,
  parameter int DEPTH  = 1024
) (
  input logic               spy_clock,
  input logic               spy_rst_n,
  fm_spy_buffer_ch_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int NW  = (DATA_W + AXI_DW - 1) / AXI_DW;
  localparam int WPR = (DATA_W <= AXI_DW) ? 1 : (NW + (NW % 2));
  localparam int RW  = $clog2(DEPTH * WPR);
  localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int PW  = WPR * AXI_DW;

  typedef enum logic [1:0] {S_CAPTURE, S_POSTTRIG, S_FROZEN, S_PLAYBACK} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wrapped_q, wrapped_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pb_ptr_q, pb_ptr_d;
  logic [AW:0]   pb_left_q, pb_left_d;
  logic          pb_done_q, pb_done_d;
  logic          wr_en, pb_issue;

  // Oldest-first window of the frozen buffer
  logic [AW-1:0] pb_start;
  logic [AW:0]   pb_count;
  assign pb_start = wrapped_q ? wr_ptr_q : '0;
  assign pb_count = wrapped_q ? (AW+1)'(DEPTH) : {1'b0, wr_ptr_q};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pb_rd_q, ax_rd_q;
  logic [DATA_W-1:0] pb_data_q;
  logic [1:0]        pb_vld_pipe_q;

  // AXI address split into entry/word; entries past DEPTH read as zero
  logic [RW-1:0] ax_entry;
  logic [WW-1:0] ax_word, ax_word_q;
  logic          ax_oor, ax_oor_q;
  logic [1:0]    ax_vld_pipe_q;
  logic [AXI_DW-1:0] rd_data_q;
  logic [WPR-1:0][AXI_DW-1:0] ax_words;

  assign ax_entry = RW'(bus.rd_addr / WPR);
  assign ax_word  = WW'(bus.rd_addr % WPR);
  assign ax_oor   = ({1'b0, ax_entry} >= (RW+1)'(DEPTH));
  assign ax_words = PW'(ax_rd_q);

  // Next-state: capture/freeze/playback control and pointer bookkeeping
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    wrapped_d = wrapped_q;
    cnt_d     = cnt_q;
    pb_ptr_d  = pb_ptr_q;
    pb_left_d = pb_left_q;
    pb_done_d = pb_done_q & bus.pb_mode[1];  // a finished ONCE re-arms when mode leaves 1x
    wr_en     = 1'b0;
    pb_issue  = 1'b0;
    case (state_q)
      S_CAPTURE, S_POSTTRIG: begin
        wr_en = bus.in_vld && (bus.pb_mode == 2'b00);
        if (bus.pb_mode[1]) state_d = S_PLAYBACK;
        else if (bus.pb_mode[0]) state_d = S_FROZEN;
        else if (state_q == S_CAPTURE) begin
          if (bus.freeze_req) begin
            if (bus.post_trig == '0) state_d = S_FROZEN;
            else begin
              state_d = S_POSTTRIG;
              cnt_d   = bus.post_trig;
            end
          end
        end else if (wr_en) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == AW'(1)) state_d = S_FROZEN;
        end
      end
      S_FROZEN: begin
        if (bus.rearm && (bus.pb_mode == 2'b00)) begin
          state_d   = S_CAPTURE;
          wr_ptr_d  = '0;
          wrapped_d = 1'b0;
          cnt_d     = '0;
        end else if (bus.pb_mode[1] && !pb_done_q) state_d = S_PLAYBACK;
      end
      S_PLAYBACK: begin
        pb_issue = bus.pb_mode[1] && (pb_left_q != '0);
        if (!bus.pb_mode[1]) state_d = S_FROZEN;
        else if (pb_issue) begin
          pb_ptr_d  = pb_ptr_q + 1'b1;
          pb_left_d = pb_left_q - 1'b1;
          if (pb_left_q == (AW+1)'(1)) begin
            if (bus.pb_mode[0]) begin
              pb_ptr_d  = pb_start;  // loop: next cycle restarts, no gap
              pb_left_d = pb_count;
            end else begin
              state_d   = S_FROZEN;
              pb_done_d = 1'b1;
            end
          end
        end else if (!bus.pb_mode[0]) begin
          state_d   = S_FROZEN;      // empty buffer in ONCE mode
          pb_done_d = 1'b1;
        end
      end
      default: state_d = S_CAPTURE;
    endcase
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == AW'(DEPTH - 1)) wrapped_d = 1'b1;
    end
    if ((state_d == S_PLAYBACK) && (state_q != S_PLAYBACK)) begin
      pb_ptr_d  = pb_start;
      pb_left_d = pb_count;
    end
  end

  // Control state registers
  always_ff @(posedge spy_clock or negedge spy_rst_n) begin
    if (!spy_rst_n) begin
      state_q   <= S_CAPTURE;
      wr_ptr_q  <= '0;
      wrapped_q <= 1'b0;
      cnt_q     <= '0;
      pb_ptr_q  <= '0;
      pb_left_q <= '0;
      pb_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      wrapped_q <= wrapped_d;
      cnt_q     <= cnt_d;
      pb_ptr_q  <= pb_ptr_d;
      pb_left_q <= pb_left_d;
      pb_done_q <= pb_done_d;
    end
  end

  // RAM: one write port, two read-first synchronous read ports; not reset
  always_ff @(posedge spy_clock) begin
    if (wr_en) mem[wr_ptr_q] <= bus.in_data;
    pb_rd_q <= mem[pb_ptr_q];
    ax_rd_q <= mem[ax_entry[AW-1:0]];
  end

  // Output pipelines: RAM stage then registered outputs
  always_ff @(posedge spy_clock or negedge spy_rst_n) begin
    if (!spy_rst_n) begin
      pb_vld_pipe_q <= '0;
      pb_data_q     <= '0;
      ax_vld_pipe_q <= '0;
      ax_word_q     <= '0;
      ax_oor_q      <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      pb_vld_pipe_q <= {pb_vld_pipe_q[0], pb_issue};
      if (pb_vld_pipe_q[0]) pb_data_q <= pb_rd_q;
      ax_vld_pipe_q <= {ax_vld_pipe_q[0], bus.rd_en};
      ax_word_q     <= ax_word;
      ax_oor_q      <= ax_oor;
      if (ax_vld_pipe_q[0]) rd_data_q <= ax_oor_q ? '0 : ax_words[ax_word_q];
    end
  end

  assign bus.pb_data      = pb_data_q;
  assign bus.pb_vld       = pb_vld_pipe_q[1];
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_vld       = ax_vld_pipe_q[1];
  assign bus.meta_wr_ptr  = wr_ptr_q;
  assign bus.meta_wrapped = wrapped_q;
  assign bus.meta_frozen  = (state_q == S_FROZEN) || (state_q == S_PLAYBACK);
endmodule

// File: tb/tb_fm_spy_buffer_ch.sv
// Directed bench for fm_spy_buffer_ch: DATA_W=180, AXI_DW=32 (WPR=6),
// DEPTH=16, so out-of-range AXI addresses (96..127) are reachable.
module tb_fm_spy_buffer_ch;
  localparam int DATA_W = 180;
  localparam int AXI_DW = 32;
  localparam int DEPTH  = 16;

  logic spy_clock = 1'b0;
  logic spy_rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 spy_clock = ~spy_clock;

  fm_spy_buffer_ch_if #(.DATA_W(DATA_W), .AXI_DW(AXI_DW), .DEPTH(DEPTH)) bus ();

  fm_spy_buffer_ch #(.DATA_W(DATA_W), .AXI_DW(AXI_DW), .DEPTH(DEPTH)) dut (
    .spy_clock (spy_clock),
    .spy_rst_n (spy_rst_n),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge spy_clock);
    #1;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    bus.in_vld  = 1'b1;
    bus.in_data = d;
    tick();
    bus.in_vld  = 1'b0;
  endtask

  task automatic do_rearm();
    bus.rearm = 1'b1;
    tick();
    bus.rearm = 1'b0;
  endtask

  task automatic axi_rd(input string tag, input int a, input logic [31:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 7'(a);
    tick();
    bus.rd_en   = 1'b0;
    chk({tag, "_vld_early"}, bus.rd_vld, 0);
    tick();
    chk({tag, "_vld"}, bus.rd_vld, 1);
    chk(tag, bus.rd_data, exp);
  endtask

  int          t1_a [9];
  logic [31:0] t1_e [9];
  logic [DATA_W-1:0] v;

  initial begin
    bus.pb_mode = 2'b00; bus.freeze_req = 1'b0; bus.rearm = 1'b0; bus.post_trig = '0;
    bus.in_data = '0; bus.in_vld = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
    t1_a = '{18, 19, 20, 21, 22, 23, 6, 96, 102};
    t1_e = '{32'hCAFEF00D, 32'h23456789, 32'hABCDEF01, 32'h12345678,
             32'h0F0F0F0F, 32'h000ABCDE, 32'h22, 32'h0, 32'h0};

    // Reset state
    tick(); tick();
    chk("rst_wr_ptr", bus.meta_wr_ptr, 0);
    chk("rst_wrapped", bus.meta_wrapped, 0);
    chk("rst_frozen", bus.meta_frozen, 0);
    chk("rst_pb_vld", bus.pb_vld, 0);
    chk("rst_rd_vld", bus.rd_vld, 0);
    chk("rst_pb_data", bus.pb_data, 0);
    spy_rst_n = 1'b1;
    tick();

    // Wrap: 20 writes into 16 entries, immediate freeze, replay once
    for (int i = 0; i < 20; i++) wr(DATA_W'(i));
    bus.freeze_req = 1'b1; bus.post_trig = '0;
    tick();
    bus.freeze_req = 1'b0;
    chk("t2_frozen", bus.meta_frozen, 1);
    chk("t2_wrapped", bus.meta_wrapped, 1);
    chk("t2_wr_ptr", bus.meta_wr_ptr, 4);
    bus.pb_mode = 2'b10;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i >= 3 && i <= 18) begin
        chk("t2_pb_vld", bus.pb_vld, 1);
        chk("t2_pb_data", bus.pb_data, 192'(i + 1));
      end else chk("t2_pb_idle", bus.pb_vld, 0);
    end
    chk("t2_frozen_after", bus.meta_frozen, 1);
    bus.pb_mode = 2'b00;
    tick();

    // AXI word layout incl. zero padding above DATA_W and out-of-range entries
    do_rearm();
    chk("t1_rearm_ptr", bus.meta_wr_ptr, 0);
    chk("t1_rearm_wrapped", bus.meta_wrapped, 0);
    chk("t1_rearm_frozen", bus.meta_frozen, 0);
    v = {20'hABCDE, 32'h0F0F0F0F, 32'h12345678, 32'hABCDEF01, 32'h23456789, 32'hCAFEF00D};
    wr(DATA_W'(32'h11)); wr(DATA_W'(32'h22)); wr(DATA_W'(32'h33)); wr(v);
    bus.pb_mode = 2'b01;
    tick();
    bus.pb_mode = 2'b00;
    chk("t1_frozen", bus.meta_frozen, 1);
    chk("t1_wr_ptr", bus.meta_wr_ptr, 4);
    for (int i = 0; i <= 9; i++) begin
      bus.rd_en = (i < 9);
      if (i < 9) bus.rd_addr = 7'(t1_a[i]);
      tick();
      if (i == 0) chk("t1_rd_vld0", bus.rd_vld, 0);
      else begin
        chk("t1_rd_vld", bus.rd_vld, 1);
        chk("t1_rd_word", bus.rd_data, t1_e[i-1]);
      end
    end
    bus.rd_en = 1'b0;

    // Post-trigger count with gapped writes
    do_rearm();
    for (int i = 0; i < 8; i++) begin
      wr(DATA_W'(32'h100 + i));
      tick();
    end
    bus.freeze_req = 1'b1; bus.post_trig = 4'd5;
    tick();
    bus.freeze_req = 1'b0;
    chk("t3_armed_not_frozen", bus.meta_frozen, 0);
    for (int j = 0; j < 8; j++) begin
      wr(DATA_W'(32'h108 + j));
      tick(); tick();
      chk("t3_frozen_step", bus.meta_frozen, (j >= 4) ? 1 : 0);
    end
    chk("t3_wr_ptr", bus.meta_wr_ptr, 13);
    axi_rd("t3_entry8", 48, 32'h108);
    axi_rd("t3_entry12", 72, 32'h10C);
    axi_rd("t3_entry13_untouched", 78, 32'hD);

    // Loop playback over 3 entries, then stop with one in-flight entry
    do_rearm();
    wr(DATA_W'(0)); wr(DATA_W'(1)); wr(DATA_W'(2));
    bus.pb_mode = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i >= 3) begin
        chk("t4_pb_vld", bus.pb_vld, 1);
        chk("t4_pb_data", bus.pb_data, 192'((i - 3) % 3));
      end else chk("t4_pb_idle", bus.pb_vld, 0);
    end
    bus.pb_mode = 2'b00;
    tick();
    chk("t4_inflight_vld", bus.pb_vld, 1);
    chk("t4_inflight_data", bus.pb_data, 1);
    tick();
    chk("t4_stop_vld", bus.pb_vld, 0);
    chk("t4_frozen", bus.meta_frozen, 1);
    do_rearm();
    chk("t4_rearm_ptr", bus.meta_wr_ptr, 0);
    chk("t4_rearm_wrapped", bus.meta_wrapped, 0);
    chk("t4_rearm_frozen", bus.meta_frozen, 0);

    // Empty buffer playback once
    bus.pb_mode = 2'b10;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t5_empty_vld", bus.pb_vld, 0);
    end
    chk("t5_frozen", bus.meta_frozen, 1);
    bus.pb_mode = 2'b00;
    tick();
    axi_rd("t5_oor", 127, 32'h0);

    // Reset during post-trigger and during playback
    do_rearm();
    wr(DATA_W'(32'h51)); wr(DATA_W'(32'h52)); wr(DATA_W'(32'h53));
    bus.freeze_req = 1'b1; bus.post_trig = 4'd4;
    tick();
    bus.freeze_req = 1'b0;
    wr(DATA_W'(32'h54));
    chk("t6_pre_rst_ptr", bus.meta_wr_ptr, 4);
    spy_rst_n = 1'b0;
    #1;
    chk("t6_rst_ptr", bus.meta_wr_ptr, 0);
    chk("t6_rst_frozen", bus.meta_frozen, 0);
    tick();
    spy_rst_n = 1'b1;
    wr(DATA_W'(32'h77)); wr(DATA_W'(32'h78)); wr(DATA_W'(32'h79)); wr(DATA_W'(32'h7A));
    chk("t6_capture_ptr", bus.meta_wr_ptr, 4);
    chk("t6_capture_not_frozen", bus.meta_frozen, 0);
    bus.pb_mode = 2'b11;
    tick(); tick(); tick(); tick();
    chk("t6_pb_running", bus.pb_vld, 1);
    spy_rst_n = 1'b0;
    #1;
    chk("t6_rst_pb_vld", bus.pb_vld, 0);
    chk("t6_rst_pb_data", bus.pb_data, 0);
    chk("t6_rst_frozen2", bus.meta_frozen, 0);
    chk("t6_rst_ptr2", bus.meta_wr_ptr, 0);
    bus.pb_mode = 2'b00;
    tick();
    spy_rst_n = 1'b1;
    tick();
    chk("t6_after_rst_frozen", bus.meta_frozen, 0);
    bus.pb_mode = 2'b01;
    tick();
    bus.pb_mode = 2'b00;
    axi_rd("t6_retained_entry0", 0, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
